// File: rtl/timer_arbiter.sv
// Round-robin APB master sharing one timer slave among NUM_REQ requesters:
// programs clear/goal/start, polls STATUS until COMPLETE, then cleans up and pulses done.
module timer_arbiter #(
    parameter int                        NUM_REQ         = 4,
    parameter int                        DATA_WIDTH      = 8,
    parameter int                        ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0]     TIMER_BASE_ADDR = '0,
    parameter int                        POLL_GAP        = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_ticks,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_REQ-1:0]              done_o,
    output logic [NUM_REQ-1:0]              err_o,
    output logic                            busy,
    output logic [ADDR_WIDTH-1:0]           paddr,
    output logic                            psel,
    output logic                            penable,
    output logic                            pwrite,
    output logic [DATA_WIDTH-1:0]           pwdata,
    input  logic [DATA_WIDTH-1:0]           prdata,
    input  logic                            pready,
    input  logic                            pslverr
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // psel must drop for at least one clock between polls, so a zero gap still idles once.
    localparam int GAP_LEN = (POLL_GAP < 1) ? 1 : POLL_GAP;
    localparam logic [1:0] ST_COMPLETE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_ZERO, S_CLR, S_GOAL, S_START, S_POLL, S_GAP, S_FIN
    } state_t;

    // APB handshake: a transfer is SETUP (psel=1, penable=0) then ACCESS (psel=1,
    // penable=1) held until pready; address/direction/data stay fixed throughout and
    // prdata/pslverr are sampled on the pready cycle. PH_IDLE keeps psel low one clock.
    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

    state_t                     state_q, state_d;
    phase_t                     phase_q, phase_d;
    logic [3:0]                 gap_cnt_q, gap_cnt_d;
    logic [NUM_REQ-1:0]         grant_q, grant_d;
    logic [PTR_W-1:0]           owner_q, owner_d;
    logic [DATA_WIDTH-1:0]      ticks_q, ticks_d;
    logic [PTR_W-1:0]           rr_q, rr_d;
    logic [NUM_REQ-1:0]         done_q, done_d;
    logic [NUM_REQ-1:0]         err_q, err_d;

    logic                       win_found;
    logic [PTR_W-1:0]           win_idx;
    logic [PTR_W:0]             cand_sum;
    logic [PTR_W-1:0]           cand;
    logic [DATA_WIDTH-1:0]      win_ticks;
    logic [PTR_W-1:0]           next_rr;
    logic                       owner_req;
    logic                       poll_complete;
    logic                       unused_status_bits;

    // First requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_q} + (PTR_W+1)'(k);
            if (cand_sum >= (PTR_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
            end
            cand = cand_sum[PTR_W-1:0];
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_ticks     = req_ticks[win_idx*DATA_WIDTH +: DATA_WIDTH];
    assign next_rr       = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
    assign owner_req     = req[owner_q];
    assign poll_complete = (prdata[3:2] == ST_COMPLETE);
    assign unused_status_bits = ^{prdata[DATA_WIDTH-1:4], prdata[1:0]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_IDLE;
            gap_cnt_q <= '0;
            grant_q   <= '0;
            owner_q   <= '0;
            ticks_q   <= '0;
            rr_q      <= '0;
            done_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            gap_cnt_q <= gap_cnt_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ticks_q   <= ticks_d;
            rr_q      <= rr_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        gap_cnt_d = gap_cnt_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ticks_d   = ticks_q;
        rr_d      = rr_q;
        done_d    = '0;
        err_d     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = win_idx;
                    ticks_d          = win_ticks;
                    rr_d             = next_rr;
                    phase_d          = PH_SETUP;
                    state_d          = (win_ticks == '0) ? S_ZERO : S_CLR;
                end
            end
            S_ZERO: begin
                // Zero delay completes without touching the timer.
                if (owner_req) begin
                    done_d[owner_q] = 1'b1;
                end
                grant_d = '0;
                phase_d = PH_IDLE;
                state_d = S_IDLE;
            end
            S_CLR, S_GOAL, S_START, S_POLL: begin
                unique case (phase_q)
                    PH_IDLE: begin
                        phase_d = PH_SETUP;
                        if (!owner_req) begin
                            state_d = S_FIN;
                        end
                    end
                    PH_SETUP: phase_d = PH_ACCESS;
                    default: begin
                        if (pready) begin
                            phase_d = PH_IDLE;
                            if (!owner_req) begin
                                state_d = S_FIN;
                            end else if (pslverr) begin
                                err_d[owner_q] = 1'b1;
                                state_d        = S_FIN;
                            end else begin
                                unique case (state_q)
                                    S_CLR:   state_d = S_GOAL;
                                    S_GOAL:  state_d = S_START;
                                    S_START: state_d = S_POLL;
                                    default: begin
                                        if (poll_complete) begin
                                            done_d[owner_q] = 1'b1;
                                            state_d         = S_FIN;
                                        end else begin
                                            gap_cnt_d = 4'(GAP_LEN - 1);
                                            state_d   = S_GAP;
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                endcase
            end
            S_GAP: begin
                if (!owner_req) begin
                    state_d = S_FIN;
                    phase_d = PH_SETUP;
                end else if (gap_cnt_q == '0) begin
                    state_d = S_POLL;
                    phase_d = PH_SETUP;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            S_FIN: begin
                // Cleanup write; its pslverr is deliberately ignored.
                unique case (phase_q)
                    PH_IDLE:  phase_d = PH_SETUP;
                    PH_SETUP: phase_d = PH_ACCESS;
                    default: begin
                        if (pready) begin
                            grant_d = '0;
                            phase_d = PH_IDLE;
                            state_d = S_IDLE;
                        end
                    end
                endcase
            end
            default: begin
                state_d = S_IDLE;
                phase_d = PH_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        if ((state_q inside {S_CLR, S_GOAL, S_START, S_POLL, S_FIN}) && (phase_q != PH_IDLE)) begin
            psel    = 1'b1;
            penable = (phase_q == PH_ACCESS);
            unique case (state_q)
                S_GOAL: begin
                    paddr  = TIMER_BASE_ADDR + ADDR_WIDTH'(1);
                    pwrite = 1'b1;
                    pwdata = ticks_q;
                end
                S_START: begin
                    paddr  = TIMER_BASE_ADDR;
                    pwrite = 1'b1;
                    pwdata = DATA_WIDTH'(1);
                end
                S_POLL: begin
                    paddr  = TIMER_BASE_ADDR;
                    pwrite = 1'b0;
                end
                default: begin
                    paddr  = TIMER_BASE_ADDR;
                    pwrite = 1'b1;
                    pwdata = '0;
                end
            endcase
        end
    end

    assign grant  = grant_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign busy   = |grant_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: arbitration vector table plus hand-written
// sequences against a small APB timer slave model with configurable wait states.
module tb_timer_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int PG = 4;

  logic clk = 1'b0;
  logic reset;
  logic [NR-1:0] req;
  logic [NR*DW-1:0] req_ticks;
  logic [NR-1:0] grant, done_o, err_o;
  logic busy;
  logic [AW-1:0] paddr;
  logic psel, penable, pwrite;
  logic [DW-1:0] pwdata, prdata;
  logic pready, pslverr;

  always #5 clk = ~clk;

  timer_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .TIMER_BASE_ADDR(32'd0), .POLL_GAP(PG)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_ticks(req_ticks),
    .grant(grant), .done_o(done_o), .err_o(err_o), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // timer slave model
  int wait_cfg = 0;
  int wcnt = 0;
  logic err_goal = 1'b0;
  logic [1:0] t_state = 2'd0;
  logic t_start = 1'b0;
  logic [DW-1:0] t_goal = '0;
  logic [DW-1:0] t_curr = '0;

  assign pready  = psel && penable && (wcnt >= wait_cfg);
  assign pslverr = pready && err_goal && pwrite && (paddr == 32'd1);
  assign prdata  = {4'b0000, t_state, 1'b0, t_start};

  always @(posedge clk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (pready && pwrite && !pslverr) begin
      if (paddr == 32'd0) begin
        t_curr <= '0;
        if (pwdata == 8'd1) begin
          t_state <= 2'd1;
          t_start <= 1'b1;
        end else begin
          t_state <= 2'd0;
          t_start <= 1'b0;
        end
      end else if (paddr == 32'd1) begin
        t_goal <= pwdata;
      end
    end else if (t_state == 2'd1) begin
      t_curr <= t_curr + 8'd1;
      if (({1'b0, t_curr} + 9'd1) >= {1'b0, t_goal}) t_state <= 2'd2;
    end
  end

  // bus monitor
  int done_cnt[NR];
  int err_cnt[NR];
  int both_cnt = 0;
  int stab_err = 0;
  int gap_err = 0;
  int pollgap_err = 0;
  int poll_pairs = 0;
  int idle_run = 0;
  int curr_at_done = -1;
  logic have_prev = 1'b0;
  logic prev_was_read = 1'b0;
  logic [AW-1:0] s_addr;
  logic s_write;
  logic [DW-1:0] s_data;
  logic [16:0] log_q[$];

  initial begin
    for (int i = 0; i < NR; i++) begin
      done_cnt[i] = 0;
      err_cnt[i] = 0;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      have_prev <= 1'b0;
      idle_run <= 0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (done_o[i]) done_cnt[i] <= done_cnt[i] + 1;
        if (err_o[i]) err_cnt[i] <= err_cnt[i] + 1;
      end
      if ((done_o & err_o) != '0) both_cnt <= both_cnt + 1;
      if (done_o[0]) curr_at_done <= int'(t_curr);
      if (!psel) begin
        idle_run <= idle_run + 1;
      end else if (!penable) begin
        s_addr <= paddr;
        s_write <= pwrite;
        s_data <= pwdata;
        if (have_prev) begin
          if (idle_run < 1) gap_err <= gap_err + 1;
          if (prev_was_read && !pwrite) begin
            poll_pairs <= poll_pairs + 1;
            if (idle_run != PG) pollgap_err <= pollgap_err + 1;
          end
        end
      end else begin
        if (paddr !== s_addr || pwrite !== s_write || pwdata !== s_data) stab_err <= stab_err + 1;
        if (pready) begin
          log_q.push_back({pwrite, paddr[7:0], pwrite ? pwdata : prdata});
          have_prev <= 1'b1;
          prev_was_read <= !pwrite;
          idle_run <= 0;
        end
      end
    end
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_session(input string name, input int idx, input logic [DW-1:0] ticks, input int max_cyc);
    int n;
    @(negedge clk);
    req_ticks[idx*DW +: DW] = ticks;
    req[idx] = 1'b1;
    n = 0;
    while (!(done_o[idx] || err_o[idx]) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({name, "_end_pulse"}, 32'(n < max_cyc), 32'd1);
    req[idx] = 1'b0;
    n = 0;
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({name, "_release"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  typedef struct packed {
    logic [NR-1:0] req;
    logic [NR-1:0] exp_grant;
  } vec_t;
  vec_t vecs[12];

  initial begin #500000; $display("FAIL watchdog: time limit reached"); $fatal(1); end

  initial begin
    int n, base, dbase, ebase, bad, wc;
    logic [16:0] e;
    logic seen;

    vecs[0]  = '{4'b1010, 4'b0010};
    vecs[1]  = '{4'b1010, 4'b1000};
    vecs[2]  = '{4'b1010, 4'b0010};
    vecs[3]  = '{4'b0101, 4'b0100};
    vecs[4]  = '{4'b0011, 4'b0001};
    vecs[5]  = '{4'b0001, 4'b0001};
    vecs[6]  = '{4'b1111, 4'b0010};
    vecs[7]  = '{4'b1111, 4'b0100};
    vecs[8]  = '{4'b1111, 4'b1000};
    vecs[9]  = '{4'b1000, 4'b1000};
    vecs[10] = '{4'b0110, 4'b0010};
    vecs[11] = '{4'b1001, 4'b1000};

    // clock/reset
    reset = 1'b1;
    req = '0;
    req_ticks = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // arbitration table, zero-tick sessions
    for (int i = 0; i < 12; i++) begin
      req = vecs[i].req;
      wc = 0;
      do begin
        @(negedge clk);
        wc++;
      end while (grant == '0 && wc < 20);
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
      @(negedge clk);
      check($sformatf("vec%0d_done", i), 32'(done_o), 32'(vecs[i].exp_grant));
      check($sformatf("vec%0d_psel", i), 32'(psel), 32'd0);
      req = '0;
      repeat (2) @(negedge clk);
    end
    check("vec_no_apb_traffic", 32'(log_q.size()), 32'd0);

    // single requester, 25 ticks, no wait states
    base = log_q.size();
    dbase = done_cnt[0];
    ebase = err_cnt[0];
    run_session("t1", 0, 8'd25, 3000);
    n = log_q.size() - base;
    check("t1_xfer_count_ok", 32'(n >= 5), 32'd1);
    exp_q.delete();
    exp_q.push_back({1'b1, 8'h00, 8'h00});
    exp_q.push_back({1'b1, 8'h01, 8'd25});
    exp_q.push_back({1'b1, 8'h00, 8'h01});
    if (n >= 5) begin
      for (int k = 0; k < 3; k++) check($sformatf("t1_xfer%0d", k), 32'(log_q[base+k]), 32'(exp_q[k]));
      check("t1_fin_write", 32'(log_q[base+n-1]), 32'({1'b1, 8'h00, 8'h00}));
      bad = 0;
      for (int k = 3; k < n - 1; k++) begin
        e = log_q[base+k];
        if (e[16] != 1'b0 || e[15:8] != 8'h00) bad++;
        if (k < n - 2 && e[3:2] == 2'd2) bad++;
      end
      check("t1_poll_reads", 32'(bad), 32'd0);
      e = log_q[base+n-2];
      check("t1_last_read_state", 32'(e[3:2]), 32'd2);
    end
    check("t1_done_once", 32'(done_cnt[0] - dbase), 32'd1);
    check("t1_no_err", 32'(err_cnt[0] - ebase), 32'd0);
    check("t1_ticks_elapsed", 32'(curr_at_done), 32'd25);

    // three wait states on every transfer
    wait_cfg = 3;
    dbase = done_cnt[0];
    bad = poll_pairs;
    run_session("t3", 0, 8'd10, 3000);
    wait_cfg = 0;
    check("t3_done_once", 32'(done_cnt[0] - dbase), 32'd1);
    check("t3_poll_pairs_seen", 32'(poll_pairs > bad), 32'd1);
    check("t3_stable", 32'(stab_err), 32'd0);

    // slave error on the GOAL write
    err_goal = 1'b1;
    base = log_q.size();
    dbase = done_cnt[0];
    ebase = err_cnt[0];
    run_session("t4", 0, 8'd7, 500);
    err_goal = 1'b0;
    n = log_q.size() - base;
    check("t4_err_once", 32'(err_cnt[0] - ebase), 32'd1);
    check("t4_no_done", 32'(done_cnt[0] - dbase), 32'd0);
    check("t4_xfer_count", 32'(n), 32'd3);
    if (n == 3) begin
      check("t4_goal_xfer", 32'(log_q[base+1]), 32'({1'b1, 8'h01, 8'd7}));
      check("t4_fin_write", 32'(log_q[base+2]), 32'({1'b1, 8'h00, 8'h00}));
    end

    // cancel mid-POLL, next requester takes over
    base = log_q.size();
    dbase = done_cnt[0];
    ebase = err_cnt[0];
    n = done_cnt[1];
    @(negedge clk);
    req_ticks[0 +: DW] = 8'd200;
    req[0] = 1'b1;
    wc = 0;
    while (!(psel && !pwrite) && wc < 200) begin
      @(negedge clk);
      wc++;
    end
    check("t5_reached_poll", 32'(wc < 200), 32'd1);
    repeat (3) @(negedge clk);
    req_ticks[DW +: DW] = 8'd0;
    req[1] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    wc = 0;
    seen = 1'b0;
    while (!done_o[1] && wc < 300) begin
      @(negedge clk);
      if (grant == 4'b0010) seen = 1'b1;
      wc++;
    end
    req[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_next_grant", 32'(seen), 32'd1);
    check("t5_done1", 32'(done_cnt[1] - n), 32'd1);
    check("t5_no_done0", 32'(done_cnt[0] - dbase), 32'd0);
    check("t5_no_err0", 32'(err_cnt[0] - ebase), 32'd0);
    if (log_q.size() > base) check("t5_fin_write", 32'(log_q[log_q.size()-1]), 32'({1'b1, 8'h00, 8'h00}));
    else check("t5_xfers_present", 32'(log_q.size() - base), 32'd1);

    // reset during an ACCESS phase
    wait_cfg = 1000;
    @(negedge clk);
    req_ticks[0 +: DW] = 8'd5;
    req[0] = 1'b1;
    wc = 0;
    while (!penable && wc < 50) begin
      @(negedge clk);
      wc++;
    end
    check("t6_in_access", 32'(penable), 32'd1);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    check("t6_psel", 32'(psel), 32'd0);
    check("t6_penable", 32'(penable), 32'd0);
    check("t6_grant", 32'(grant), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_pulses", 32'({done_o, err_o}), 32'd0);
    reset = 1'b0;
    wait_cfg = 0;
    @(negedge clk);
    req_ticks = '0;
    req = 4'b0011;
    wc = 0;
    do begin
      @(negedge clk);
      wc++;
    end while (grant == '0 && wc < 20);
    check("t6_rr_reset_grant", 32'(grant), 32'd1);
    @(negedge clk);
    check("t6_rr_reset_done", 32'(done_o), 32'd1);
    req = '0;
    repeat (3) @(negedge clk);

    // whole-run protocol checks
    check("apb_signals_stable", 32'(stab_err), 32'd0);
    check("apb_psel_gap", 32'(gap_err), 32'd0);
    check("poll_gap_len", 32'(pollgap_err), 32'd0);
    check("done_err_exclusive", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
